cv32e41p_instr_packer: RTL and testbench
========================================

CV32E41P_INSTR_PACKER -- requirements
Module: cv32e41p_instr_packer

Packs a stream of variable-length RISC-V instructions (16-bit compressed / 32-bit) into word-aligned 32-bit words with halfword byte enables. It is the write-side counterpart to the fetch-side instruction aligner.

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 instr_valid_i  input  1  instruction offered.
REQ-005 instr_ready_o  output  1  instruction accepted when valid && ready.
REQ-006 instr_i  input  32  instruction; instr_i[1:0]==2'b11 means 32-bit, else 16-bit in instr_i[15:0].
REQ-007 instr_addr_i  input  32  instruction byte address; bit 0 is always 0.
REQ-008 flush_i  input  1  request to emit any held halfword.
REQ-009 word_valid_o  output  1  packed word available.
REQ-010 word_ready_i  input  1  sink accepts word when valid && ready.
REQ-011 word_o  output  32  packed word.
REQ-012 word_addr_o  output  32  word address; bits [1:0] are always 2'b00.
REQ-013 word_be_o  output  4  byte enables: 4'b0011, 4'b1100 or 4'b1111 only.
REQ-014 idle_o  output  1  no residue held and no word pending.

Function
REQ-015 Internal state SHALL be:
- EMPTY: no residue.
- HALF: 16-bit residue res_q, at byte address res_addr_q with res_addr_q[1]==0, held as the low half of a word.
REQ-016 The block SHALL hold one output register (word_o, word_addr_o, word_be_o, word_valid_o).
REQ-017 Output register SHALL be loadable in a cycle only if out_free = !word_valid_o || word_ready_i.
REQ-018 While word_valid_o && !word_ready_i, all word_* outputs SHALL be held stable.
REQ-019 Expected address exp_q SHALL be updated on every accepted instruction:
- exp_q = instr_addr_i + 2 for a 16-bit instruction.
- exp_q = instr_addr_i + 4 for a 32-bit instruction.
- Addition is 32-bit modulo, wrapping 0xFFFF_FFFE+2 to 0.
REQ-020 disc = HALF && instr_valid_i && (instr_addr_i != exp_q).
REQ-021 instr_ready_o = out_free && !(HALF && (flush_i || disc)), combinational.
REQ-022 In EMPTY, accepted 16-bit instruction with addr[1]==0: res_q = instr_i[15:0], res_addr_q = addr → HALF; no word emitted.
REQ-023 In EMPTY, accepted 32-bit instruction with addr[1]==0: emit {instr_i}, be 4'b1111, addr → EMPTY.
REQ-024 In EMPTY, accepted 16-bit instruction with addr[1]==1: emit {instr_i[15:0],16'h0}, be 4'b1100, addr&~3 → EMPTY.
REQ-025 In EMPTY, accepted 32-bit instruction with addr[1]==1 (split):
- Emit {instr_i[15:0],16'h0}, be 4'b1100, addr&~3.
- res_q = instr_i[31:16], res_addr_q = addr+2 → HALF.
REQ-026 In HALF, accepted 16-bit instruction: emit {instr_i[15:0],res_q}, be 4'b1111, res_addr_q → EMPTY.
REQ-027 In HALF, accepted 32-bit instruction:
- Emit {instr_i[15:0],res_q}, be 4'b1111, res_addr_q.
- res_q = instr_i[31:16], res_addr_q = res_addr_q+4 → stay HALF.
REQ-028 In HALF with (flush_i || disc) and out_free:
- Emit {16'h0,res_q}, be 4'b0011, res_addr_q → EMPTY.
- No instruction is accepted that cycle; the pending instruction is processed from EMPTY in a later cycle.
REQ-029 In HALF with (flush_i || disc) and !out_free: no state change; instr_ready_o = 0.
REQ-030 flush_i in EMPTY SHALL have no effect; instructions are accepted normally.
REQ-031 flush_i and disc together SHALL produce exactly one residue emission.
REQ-032 Throughput: one instruction per cycle when word_ready_i is held high, except for the one-cycle residue emission of REQ-028.
REQ-033 idle_o = (state==EMPTY) && !word_valid_o.
REQ-034 Latency: an emitted word SHALL appear on word_* in the cycle after the accepting edge (registered output).

Reset
REQ-035 On rst, in the cycle rst is sampled high:
- state=EMPTY; word_valid_o=0.
- word_o, word_addr_o, word_be_o, res_q, res_addr_q, exp_q all = 0.
REQ-036 Reset mid-operation SHALL discard any residue and pending word without emitting them.
REQ-037 instr_ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-038 Two 16-bit instructions:
- Stimulus: 0x0001 @0x100, then 0x4501 @0x102; word_ready_i=1.
- Response: one word 0x4501_0001, addr 0x100, be 4'b1111; idle_o=1 afterwards.
REQ-039 Misaligned 32-bit start:
- Stimulus: 0x0010_0093 @0x202, then flush_i.
- Response: word 0x0093_0000, addr 0x200, be 4'b1100; then word 0x0000_0010, addr 0x204, be 4'b0011.
REQ-040 Discontinuity:
- Stimulus: 0x0001 @0x300, then 0x0002 @0x400.
- Response: word 0x0000_0001 @0x300 be 4'b0011 while instr_ready_o=0; the following cycle holds residue 0x0002 @0x400.
REQ-041 Backpressure:
- Stimulus: word_ready_i=0 for 5 cycles with a word pending.
- Response: word_* stable for all 5 cycles; instr_ready_o=0; the word drains on the first cycle word_ready_i=1.
REQ-042 Chained 32-bit in HALF:
- Stimulus: 0x0001 @0x0, then 32-bit 0xAAAA_BBBF @0x2, then 16-bit 0x0005 @0x6.
- Response: words 0xBBBF_0001 @0x0 and 0x0005_AAAA @0x4, both be 4'b1111.
REQ-043 Reset while HALF:
- Stimulus: assert rst while holding residue.
- Response: no word emitted; word_valid_o=0 and idle_o=1 the next cycle.

Source files
------------

// File: rtl/cv32e41p_instr_packer.sv
// Packs a stream of 16/32-bit RISC-V instructions into word-aligned 32-bit words
// with halfword byte enables, holding at most one low halfword as residue.
module cv32e41p_instr_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] instr_addr_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic [31:0] word_addr_o,
  output logic [3:0]  word_be_o,
  output logic        idle_o
);

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] res_q, res_d;
  logic [31:0] res_addr_q, res_addr_d;
  logic [31:0] exp_q, exp_d;

  logic        vld_p0;
  logic [31:0] word_p0, addr_p0;
  logic [3:0]  be_p0;

  logic        vld_p1;
  logic [31:0] word_p1, addr_p1;
  logic [3:0]  be_p1;

  logic out_free, is32, disc, emit_res, accept;

  assign out_free      = !vld_p1 || word_ready_i;
  assign is32          = (instr_i[1:0] == 2'b11);
  assign disc          = (state_q == HALF) && instr_valid_i && (instr_addr_i != exp_q);
  assign emit_res      = (state_q == HALF) && (flush_i || disc);
  assign instr_ready_o = out_free && !emit_res;
  assign accept        = instr_valid_i && instr_ready_o;

  // Stage p0: decide the word to emit and the next residue
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    res_addr_d = res_addr_q;
    exp_d      = exp_q;
    vld_p0     = 1'b0;
    word_p0    = 32'h0;
    addr_p0    = 32'h0;
    be_p0      = 4'h0;
    if (emit_res) begin
      // Residue leaves alone; the offered instruction waits for EMPTY.
      if (out_free) begin
        vld_p0  = 1'b1;
        word_p0 = {16'h0, res_q};
        addr_p0 = res_addr_q;
        be_p0   = 4'b0011;
        state_d = EMPTY;
      end
    end else if (accept) begin
      exp_d = instr_addr_i + (is32 ? 32'd4 : 32'd2);
      if (state_q == HALF) begin
        vld_p0  = 1'b1;
        word_p0 = {instr_i[15:0], res_q};
        addr_p0 = res_addr_q;
        be_p0   = 4'b1111;
        if (is32) begin
          res_d      = instr_i[31:16];
          res_addr_d = res_addr_q + 32'd4;
        end else begin
          state_d = EMPTY;
        end
      end else if (!instr_addr_i[1]) begin
        if (is32) begin
          vld_p0  = 1'b1;
          word_p0 = instr_i;
          addr_p0 = instr_addr_i;
          be_p0   = 4'b1111;
        end else begin
          res_d      = instr_i[15:0];
          res_addr_d = instr_addr_i;
          state_d    = HALF;
        end
      end else begin
        vld_p0  = 1'b1;
        word_p0 = {instr_i[15:0], 16'h0};
        addr_p0 = {instr_addr_i[31:2], 2'b00};
        be_p0   = 4'b1100;
        if (is32) begin
          res_d      = instr_i[31:16];
          res_addr_d = instr_addr_i + 32'd2;
          state_d    = HALF;
        end
      end
    end
  end

  // Stage p1: registered output word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      res_q      <= 16'h0;
      res_addr_q <= 32'h0;
      exp_q      <= 32'h0;
      vld_p1     <= 1'b0;
      word_p1    <= 32'h0;
      addr_p1    <= 32'h0;
      be_p1      <= 4'h0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      res_addr_q <= res_addr_d;
      exp_q      <= exp_d;
      if (out_free) begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          word_p1 <= word_p0;
          addr_p1 <= addr_p0;
          be_p1   <= be_p0;
        end
      end
    end
  end

  assign word_valid_o = vld_p1;
  assign word_o       = word_p1;
  assign word_addr_o  = addr_p1;
  assign word_be_o    = be_p1;
  assign idle_o       = (state_q == EMPTY) && !vld_p1;

endmodule

// File: tb/tb_cv32e41p_instr_packer.sv
// Bench for cv32e41p_instr_packer: directed vector table, reset corner case,
// and randomized traffic against a halfword-level reference model.
module tb_cv32e41p_instr_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] instr_addr_i;
  logic        flush_i;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_o;
  logic [31:0] word_addr_o;
  logic [3:0]  word_be_o;
  logic        idle_o;

  cv32e41p_instr_packer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .instr_i      (instr_i),
    .instr_addr_i (instr_addr_i),
    .flush_i      (flush_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_o       (word_o),
    .word_addr_o  (word_addr_o),
    .word_be_o    (word_be_o),
    .idle_o       (idle_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fl;
    logic        wr;
    logic        rdy;
    logic        wv;
    logic [31:0] w;
    logic [31:0] wa;
    logic [3:0]  be;
    logic        idle;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic v, logic [31:0] instr, logic [31:0] addr, logic fl,
                              logic wr, logic rdy, logic wv, logic [31:0] w,
                              logic [31:0] wa, logic [3:0] be, logic idle);
    vec_t r;
    r.v = v; r.instr = instr; r.addr = addr; r.fl = fl; r.wr = wr; r.rdy = rdy;
    r.wv = wv; r.w = w; r.wa = wa; r.be = be; r.idle = idle;
    vt.push_back(r);
  endfunction

  // Reference model: instructions are split into addressed halfwords; a low
  // halfword waits for its partner, anything else leaves as soon as possible.
  bit          m_pend;
  logic [15:0] m_pdat;
  logic [31:0] m_paddr;
  bit          m_ov;
  logic [31:0] m_ow, m_oa;
  logic [3:0]  m_obe;
  logic [31:0] seq_addr;

  function automatic bit m_free();
    return !m_ov || word_ready_i;
  endfunction

  function automatic bit m_flushres();
    return m_pend && (flush_i || (instr_valid_i && instr_addr_i != m_paddr + 32'd2));
  endfunction

  function automatic bit m_rdy();
    return m_free() && !m_flushres();
  endfunction

  task automatic m_reset();
    m_pend = 0; m_pdat = 0; m_paddr = 0;
    m_ov = 0; m_ow = 0; m_oa = 0; m_obe = 0;
  endtask

  task automatic m_edge();
    bit          emit = 0;
    bit          free = m_free();
    logic [31:0] ew = 0, ea = 0;
    logic [3:0]  ebe = 0;
    logic [15:0] hw[$];
    logic [31:0] ha[$];
    if (m_flushres()) begin
      if (free) begin
        emit = 1; ew = {16'h0, m_pdat}; ea = m_paddr; ebe = 4'b0011; m_pend = 0;
      end
    end else if (instr_valid_i && free) begin
      hw.push_back(instr_i[15:0]); ha.push_back(instr_addr_i);
      if (instr_i[1:0] == 2'b11) begin
        hw.push_back(instr_i[31:16]); ha.push_back(instr_addr_i + 32'd2);
      end
      seq_addr = instr_addr_i + 32'(2 * hw.size());
      for (int k = 0; k < hw.size(); k++) begin
        if (m_pend) begin
          emit = 1; ew = {hw[k], m_pdat}; ea = m_paddr; ebe = 4'b1111; m_pend = 0;
        end else if (!ha[k][1]) begin
          m_pend = 1; m_pdat = hw[k]; m_paddr = ha[k];
        end else begin
          emit = 1; ew = {hw[k], 16'h0}; ea = ha[k] - 32'd2; ebe = 4'b1100;
        end
      end
    end
    if (emit) begin
      m_ov = 1; m_ow = ew; m_oa = ea; m_obe = ebe;
    end else if (free) begin
      m_ov = 0;
    end
  endtask

  task automatic drive(logic v, logic [31:0] instr, logic [31:0] addr, logic fl, logic wr);
    instr_valid_i = v; instr_i = instr; instr_addr_i = addr; flush_i = fl; word_ready_i = wr;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("reset word_valid", 32'(word_valid_o), 32'd0);
    check("reset word", word_o, 32'h0);
    check("reset addr", word_addr_o, 32'h0);
    check("reset be", 32'(word_be_o), 32'h0);
    check("reset idle", 32'(idle_o), 32'd1);
    rst = 1'b0;
    #1;
    check("ready after reset", 32'(instr_ready_o), 32'd1);

    //  v  instr          addr           fl wr rdy wv word          waddr         be    idle
    add(1, 32'h0001,      32'h100,       0, 1, 1,  0, 0,            0,            0,    0);
    add(1, 32'h4501,      32'h102,       0, 1, 1,  1, 32'h45010001, 32'h100,      4'hF, 0);
    add(0, 0,             0,             0, 1, 1,  0, 0,            0,            0,    1);
    add(1, 32'h00100093,  32'h202,       0, 1, 1,  1, 32'h00930000, 32'h200,      4'hC, 0);
    add(0, 0,             0,             1, 1, 0,  1, 32'h00000010, 32'h204,      4'h3, 0);
    add(0, 0,             0,             0, 1, 1,  0, 0,            0,            0,    1);
    add(1, 32'h0001,      32'h300,       0, 1, 1,  0, 0,            0,            0,    0);
    add(1, 32'h0002,      32'h400,       0, 1, 0,  1, 32'h00000001, 32'h300,      4'h3, 0);
    add(1, 32'h0002,      32'h400,       0, 1, 1,  0, 0,            0,            0,    0);
    add(0, 0,             0,             1, 1, 0,  1, 32'h00000002, 32'h400,      4'h3, 0);
    add(0, 0,             0,             0, 1, 1,  0, 0,            0,            0,    1);
    add(1, 32'h0001,      32'h0,         0, 1, 1,  0, 0,            0,            0,    0);
    add(1, 32'hAAAABBBF,  32'h2,         0, 1, 1,  1, 32'hBBBF0001, 32'h0,        4'hF, 0);
    add(1, 32'h0005,      32'h6,         0, 1, 1,  1, 32'h0005AAAA, 32'h4,        4'hF, 0);
    add(0, 0,             0,             0, 1, 1,  0, 0,            0,            0,    1);
    add(1, 32'h0001,      32'h500,       1, 1, 1,  0, 0,            0,            0,    0);
    add(0, 0,             0,             1, 1, 0,  1, 32'h00000001, 32'h500,      4'h3, 0);
    add(1, 32'h0009,      32'h600,       0, 1, 1,  0, 0,            0,            0,    0);
    add(1, 32'h000D,      32'h700,       1, 1, 0,  1, 32'h00000009, 32'h600,      4'h3, 0);
    add(0, 0,             0,             0, 1, 1,  0, 0,            0,            0,    1);
    add(1, 32'h1234,      32'h802,       0, 1, 1,  1, 32'h12340000, 32'h800,      4'hC, 0);
    add(1, 32'h12345693,  32'h900,       0, 1, 1,  1, 32'h12345693, 32'h900,      4'hF, 0);
    for (int k = 0; k < 5; k++)
      add(1, 32'h0001,    32'h904,       0, 0, 0,  1, 32'h12345693, 32'h900,      4'hF, 0);
    add(1, 32'h0001,      32'h904,       0, 1, 1,  0, 0,            0,            0,    0);
    add(0, 0,             0,             1, 0, 0,  1, 32'h00000001, 32'h904,      4'h3, 0);
    add(0, 0,             0,             0, 0, 0,  1, 32'h00000001, 32'h904,      4'h3, 0);
    add(0, 0,             0,             0, 1, 1,  0, 0,            0,            0,    1);
    add(1, 32'h11112223,  32'hA02,       0, 1, 1,  1, 32'h22230000, 32'hA00,      4'hC, 0);
    add(0, 0,             0,             1, 0, 0,  1, 32'h22230000, 32'hA00,      4'hC, 0);
    add(0, 0,             0,             1, 1, 0,  1, 32'h00001111, 32'hA04,      4'h3, 0);
    add(0, 0,             0,             0, 1, 1,  0, 0,            0,            0,    1);
    add(1, 32'h0001,      32'hFFFFFFFC,  0, 1, 1,  0, 0,            0,            0,    0);
    add(1, 32'hCCCCDDDF,  32'hFFFFFFFE,  0, 1, 1,  1, 32'hDDDF0001, 32'hFFFFFFFC, 4'hF, 0);
    add(1, 32'h0005,      32'h2,         0, 1, 1,  1, 32'h0005CCCC, 32'h0,        4'hF, 0);
    add(0, 0,             0,             0, 1, 1,  0, 0,            0,            0,    1);

    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].instr, vt[i].addr, vt[i].fl, vt[i].wr);
      @(negedge clk);
      check($sformatf("vec%0d ready", i), 32'(instr_ready_o), 32'(vt[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d word_valid", i), 32'(word_valid_o), 32'(vt[i].wv));
      check($sformatf("vec%0d idle", i), 32'(idle_o), 32'(vt[i].idle));
      if (vt[i].wv) begin
        check($sformatf("vec%0d word", i), word_o, vt[i].w);
        check($sformatf("vec%0d addr", i), word_addr_o, vt[i].wa);
        check($sformatf("vec%0d be", i), 32'(word_be_o), 32'(vt[i].be));
      end
    end

    // Reset while a residue is held: nothing may come out afterwards.
    drive(1, 32'h0001, 32'h50, 0, 1);
    @(posedge clk);
    #1;
    check("half before reset idle", 32'(idle_o), 32'd0);
    drive(0, 0, 0, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset-in-half word_valid", 32'(word_valid_o), 32'd0);
    check("reset-in-half idle", 32'(idle_o), 32'd1);
    check("reset-in-half ready", 32'(instr_ready_o), 32'd1);
    drive(0, 0, 0, 1, 1);
    @(posedge clk);
    #1;
    check("reset-in-half no residue", 32'(word_valid_o), 32'd0);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    drive(0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    seq_addr = 32'h1000;
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] ins, adr;
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[1:0] = 2'b11;
      else if (ins[1:0] == 2'b11) ins[1:0] = 2'b00;
      adr = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFE) : seq_addr;
      drive($urandom_range(0, 3) != 0, ins, adr, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0);
      @(negedge clk);
      check("rand ready", 32'(instr_ready_o), 32'(m_rdy()));
      check("rand idle", 32'(idle_o), 32'(!m_pend && !m_ov));
      check("rand word_valid", 32'(word_valid_o), 32'(m_ov));
      if (m_ov) begin
        check("rand word", word_o, m_ow);
        check("rand addr", word_addr_o, m_oa);
        check("rand be", 32'(word_be_o), 32'(m_obe));
      end
      @(posedge clk);
      m_edge();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
